// File: rtl/clkdiv_pkg.sv
// Shared constants, divisor type and half-period helper for the clkdiv_multi generator.
// Build option: CLKDIV_PHASE_ALIGN_EN (see clkdiv_multi).
package clkdiv_pkg;

    localparam int unsigned DEFAULT_DIV_C = 455;
    localparam int unsigned DIV_WIDTH_C   = 16;

    typedef logic [DIV_WIDTH_C-1:0] div_t;

    // High time of the divided clock: ceil(D/2), computed one bit wider than D
    // so that D = 2**width-1 cannot overflow.
    function automatic logic [32:0] half_period(input logic [31:0] d, input int unsigned width);
        logic [32:0] mask;
        logic [32:0] dx;
        mask = (33'd1 << width) - 33'd1;
        dx   = {1'b0, d} & mask;
        return (dx + 33'd1) >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active and pending divisors, clock-enable pulse and
// registered near-50% divided clock. Divisor changes only take effect on a period boundary.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH       = $bits(div_t),
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             restart,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    output logic             pending,
    output logic             ce,
    output logic             clk_div
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] d_act;
    logic [WIDTH-1:0] d_pend;
    logic [32:0]      h_full;
    logic             halted;
    logic             wrap;
    logic             idle;
    logic             apply;
    logic             below_half;

    always_comb begin
        h_full     = half_period(32'(d_act), WIDTH);
        halted     = (d_act == '0);
        wrap       = !halted && (cnt == d_act - WIDTH'(1));
        idle       = !run || restart || halted;
        // A pending divisor waits for the end of the running period unless the
        // channel is not producing a clock at all.
        apply      = pending && (idle || wrap);
        below_half = (33'(cnt) < h_full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            d_act   <= WIDTH'(DEFAULT_DIV);
            d_pend  <= '0;
            pending <= 1'b0;
            ce      <= 1'b0;
            clk_div <= 1'b0;
        end else begin
            if (idle) begin
                cnt     <= '0;
                ce      <= 1'b0;
                clk_div <= 1'b0;
            end else begin
                cnt     <= wrap ? '0 : cnt + WIDTH'(1);
                ce      <= wrap;
                clk_div <= below_half;
            end
            if (apply) begin
                d_act <= d_pend;
                cnt   <= '0;
            end
            if (load) begin
                d_pend <= div_in;
            end
            // A load coinciding with an apply re-arms pending for the next boundary.
            pending <= load | (pending & ~apply);
        end
    end

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock-enable / divided-clock generator gated by synchronised PLL lock.
// Define CLKDIV_PHASE_ALIGN_EN to add align_i, which restarts all channels in phase.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned WIDTH       = $bits(div_t),
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      lock_i,
`ifdef CLKDIV_PHASE_ALIGN_EN
    input  logic                      align_i,
`endif
    input  logic [CHANNELS*WIDTH-1:0] div_i,
    input  logic [CHANNELS-1:0]       div_load,
    output logic                      locked_o,
    output logic [CHANNELS-1:0]       pending_o,
    output logic [CHANNELS-1:0]       ce_o,
    output logic [CHANNELS-1:0]       clk_o
);

    logic lock_meta;
    logic lock_sync;
    logic restart;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= lock_i;
            lock_sync <= lock_meta;
        end
    end

    assign locked_o = lock_sync;

`ifdef CLKDIV_PHASE_ALIGN_EN
    assign restart = lock_sync & align_i;
`else
    assign restart = 1'b0;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clkdiv_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .run     (lock_sync),
            .restart (restart),
            .load    (div_load[i]),
            .div_in  (div_i[i*WIDTH +: WIDTH]),
            .pending (pending_o[i]),
            .ce      (ce_o[i]),
            .clk_div (clk_o[i])
        );
    end

endmodule
